// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the data-memory bus controller.
// State encoding, default widths and the timeout read value.
package cpu_bus_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } bus_state_e;

    // Every bit of cpu_rdata takes this value after a timed-out cycle
    localparam logic ERR_RDATA_BIT = 1'b1;

endpackage

// File: rtl/bus_tristate.sv
// Bidirectional data bus pad: drives when enabled and
// always returns the value seen on the bus.
module bus_tristate #(
    parameter int W = 8
) (
    input  logic         oe_i,
    input  logic [W-1:0] dout_i,
    output logic [W-1:0] din_o,
    inout  wire  [W-1:0] bus_io
);

    assign bus_io = oe_i ? dout_i : {W{1'bz}};
    assign din_o  = bus_io;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequenced data-memory bus cycle: SETUP, ACCESS with wait states,
// optional ready handshake with timeout, then a one-cycle DONE.
module mem_bus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = 1,
    parameter int USE_READY   = 0,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] ADDRESS,
    inout  wire  [DATA_W-1:0] DATA_BUS,
    output logic              M_read,
    output logic              M_write,
    input  logic              mem_ready
);

    bus_state_e        state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              oe_q;
    logic              rd_q;
    logic              wr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [3:0]        wait_q;
    logic [7:0]        to_q;
    logic [DATA_W-1:0] bus_in;

    logic wait_over;
    logic ready_ok;
    logic timed_out;

    assign wait_over = (wait_q == 4'(WAIT_STATES));
    assign ready_ok  = (USE_READY == 0) || mem_ready;
    assign timed_out = (to_q >= 8'(TIMEOUT - 1));

    bus_tristate #(.W(DATA_W)) u_pad (
        .oe_i   (oe_q),
        .dout_i (wdata_q),
        .din_o  (bus_in),
        .bus_io (DATA_BUS)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            oe_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= '0;
            to_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        oe_q    <= cpu_we;
                        busy_q  <= 1'b1;
                        wait_q  <= '0;
                        to_q    <= '0;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    rd_q    <= ~we_q;
                    wr_q    <= we_q;
                    state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (!wait_over) begin
                        wait_q <= wait_q + 4'd1;
                    end else if (ready_ok || timed_out) begin
                        // Exit edge: strobes drop and read data is captured
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= ~ready_ok;
                        rdata_q <= ready_ok ? bus_in
                                            : {DATA_W{ERR_RDATA_BIT}};
                        state_q <= ST_DONE;
                    end
                    if (wait_over && !ready_ok && to_q != 8'hFF) begin
                        to_q <= to_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_busy  = busy_q;
    assign cpu_done  = done_q;
    assign cpu_err   = err_q;
    assign ADDRESS   = addr_q;
    assign M_read    = rd_q;
    assign M_write   = wr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: three instances cover the
// plain, zero-wait and ready/timeout configurations.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_a = 1'b0;
    logic req_b = 1'b0;
    logic req_c = 1'b0;
    logic we = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic ready = 1'b0;
    logic [7:0] mem_a = 8'h00;
    logic [7:0] mem_b = 8'h00;
    logic [7:0] mem_c = 8'h00;

    logic [7:0] rdata_a, rdata_b, rdata_c;
    logic [7:0] adr_a, adr_b, adr_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    logic err_a, err_b, err_c;
    logic rd_a, rd_b, rd_c;
    logic wr_a, wr_b, wr_c;

    tri1 [7:0] bus_a;
    tri1 [7:0] bus_b;
    tri1 [7:0] bus_c;

    assign bus_a = rd_a ? mem_a : 8'hzz;
    assign bus_b = rd_b ? mem_b : 8'hzz;
    assign bus_c = rd_c ? mem_c : 8'hzz;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(
        .WAIT_STATES(1), .USE_READY(0), .TIMEOUT(15)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .cpu_req(req_a), .cpu_we(we),
        .cpu_addr(addr), .cpu_wdata(wdata), .cpu_rdata(rdata_a),
        .cpu_busy(busy_a), .cpu_done(done_a), .cpu_err(err_a),
        .ADDRESS(adr_a), .DATA_BUS(bus_a), .M_read(rd_a),
        .M_write(wr_a), .mem_ready(ready)
    );

    mem_bus_ctrl #(
        .WAIT_STATES(0), .USE_READY(0), .TIMEOUT(15)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .cpu_req(req_b), .cpu_we(we),
        .cpu_addr(addr), .cpu_wdata(wdata), .cpu_rdata(rdata_b),
        .cpu_busy(busy_b), .cpu_done(done_b), .cpu_err(err_b),
        .ADDRESS(adr_b), .DATA_BUS(bus_b), .M_read(rd_b),
        .M_write(wr_b), .mem_ready(ready)
    );

    mem_bus_ctrl #(
        .WAIT_STATES(2), .USE_READY(1), .TIMEOUT(4)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .cpu_req(req_c), .cpu_we(we),
        .cpu_addr(addr), .cpu_wdata(wdata), .cpu_rdata(rdata_c),
        .cpu_busy(busy_c), .cpu_done(done_c), .cpu_err(err_c),
        .ADDRESS(adr_c), .DATA_BUS(bus_c), .M_read(rd_c),
        .M_write(wr_c), .mem_ready(ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_excl", {29'd0, rd_a & wr_a, rd_b & wr_b, rd_c & wr_c}, 32'd0);
        end
    end

    logic saw;

    initial begin
        step();
        step();
        chk("rst_done", done_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_wr", wr_a, 1'b0);
        chk("rst_rd", rd_c, 1'b0);
        chk("rst_addr", adr_b, 8'h00);
        chk("rst_rdata", rdata_c, 8'h00);
        chk("rst_bus", bus_a, 8'hFF);
        rst_n = 1'b1;
        step();

        // Reset asserted in the middle of a write
        we = 1'b1; addr = 8'h77; wdata = 8'hA5; req_a = 1'b1;
        step();
        req_a = 1'b0;
        chk("t1_setup_bus", bus_a, 8'hA5);
        step();
        chk("t1_acc_wr", wr_a, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_wr", wr_a, 1'b0);
        chk("t1_async_bus", bus_a, 8'hFF);
        chk("t1_async_busy", busy_a, 1'b0);
        step();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            saw = saw | done_a;
        end
        chk("t1_no_done", saw, 1'b0);

        // Write, one wait state
        we = 1'b1; addr = 8'h3C; wdata = 8'h5A; req_a = 1'b1;
        step();
        req_a = 1'b0; addr = 8'hFF; wdata = 8'h00;
        chk("t2_c1_bus", bus_a, 8'h5A);
        chk("t2_c1_wr", wr_a, 1'b0);
        chk("t2_c1_addr", adr_a, 8'h3C);
        chk("t2_c1_busy", busy_a, 1'b1);
        step();
        chk("t2_c2_wr", wr_a, 1'b1);
        chk("t2_c2_addr", adr_a, 8'h3C);
        chk("t2_c2_bus", bus_a, 8'h5A);
        chk("t2_c2_done", done_a, 1'b0);
        step();
        chk("t2_c3_wr", wr_a, 1'b1);
        chk("t2_c3_done", done_a, 1'b0);
        step();
        chk("t2_c4_done", done_a, 1'b1);
        chk("t2_c4_busy", busy_a, 1'b0);
        chk("t2_c4_err", err_a, 1'b0);
        chk("t2_c4_wr", wr_a, 1'b0);
        chk("t2_c4_bus", bus_a, 8'hFF);
        chk("t2_c4_addr", adr_a, 8'h3C);
        step();

        // Zero-wait read
        we = 1'b0; addr = 8'h10; mem_b = 8'hC3; req_b = 1'b1;
        step();
        req_b = 1'b0;
        chk("t3_c1_rd", rd_b, 1'b0);
        chk("t3_c1_bus", bus_b, 8'hFF);
        chk("t3_c1_addr", adr_b, 8'h10);
        step();
        chk("t3_c2_rd", rd_b, 1'b1);
        chk("t3_c2_bus", bus_b, 8'hC3);
        chk("t3_c2_done", done_b, 1'b0);
        step();
        chk("t3_c3_rd", rd_b, 1'b0);
        chk("t3_c3_done", done_b, 1'b1);
        chk("t3_c3_rdata", rdata_b, 8'hC3);
        chk("t3_c3_bus", bus_b, 8'hFF);
        step();

        // Ready handshake, early ready ignored
        we = 1'b0; addr = 8'h40; mem_c = 8'h3E; req_c = 1'b1;
        step();
        req_c = 1'b0;
        chk("t4_c1_rd", rd_c, 1'b0);
        step();
        ready = 1'b1;
        chk("t4_c2_rd", rd_c, 1'b1);
        step();
        ready = 1'b0;
        chk("t4_c3_rd", rd_c, 1'b1);
        chk("t4_c3_done", done_c, 1'b0);
        step();
        chk("t4_c4_rd", rd_c, 1'b1);
        step();
        chk("t4_c5_rd", rd_c, 1'b1);
        step();
        ready = 1'b1;
        chk("t4_c6_rd", rd_c, 1'b1);
        chk("t4_c6_done", done_c, 1'b0);
        step();
        ready = 1'b0;
        chk("t4_c7_done", done_c, 1'b1);
        chk("t4_c7_err", err_c, 1'b0);
        chk("t4_c7_rdata", rdata_c, 8'h3E);
        chk("t4_c7_rd", rd_c, 1'b0);
        step();

        // Timeout with ready stuck low, then a normal access
        addr = 8'h55; mem_c = 8'h12; req_c = 1'b1;
        step();
        req_c = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t5_c7_rd", rd_c, 1'b1);
        chk("t5_c7_done", done_c, 1'b0);
        step();
        chk("t5_c8_done", done_c, 1'b1);
        chk("t5_c8_err", err_c, 1'b1);
        chk("t5_c8_rdata", rdata_c, 8'hFF);
        chk("t5_c8_strb", {rd_c, wr_c}, 2'b00);
        step();
        ready = 1'b1; req_c = 1'b1;
        step();
        req_c = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("t5_n_done0", done_c, 1'b0);
        step();
        chk("t5_n_done", done_c, 1'b1);
        chk("t5_n_err", err_c, 1'b0);
        chk("t5_n_rdata", rdata_c, 8'h12);
        ready = 1'b0;
        step();

        // Request held high, address changed while busy
        we = 1'b0; addr = 8'h21; mem_a = 8'h6D; req_a = 1'b1;
        step();
        addr = 8'h99;
        chk("t6_c1_addr", adr_a, 8'h21);
        step();
        chk("t6_c2_addr", adr_a, 8'h21);
        chk("t6_c2_rd", rd_a, 1'b1);
        step();
        step();
        chk("t6_c4_done", done_a, 1'b1);
        chk("t6_c4_rdata", rdata_a, 8'h6D);
        chk("t6_c4_addr", adr_a, 8'h21);
        step();
        chk("t6_c5_busy", busy_a, 1'b0);
        chk("t6_c5_done", done_a, 1'b0);
        mem_a = 8'h4B;
        step();
        req_a = 1'b0;
        chk("t6_c6_addr", adr_a, 8'h99);
        chk("t6_c6_busy", busy_a, 1'b1);
        step();
        step();
        step();
        chk("t6_c9_done", done_a, 1'b1);
        chk("t6_c9_rdata", rdata_a, 8'h4B);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
